// File: rtl/mac_acc_8_bit_if.sv
// Operand/result handshake bundle between the multiply-accumulate stage and its
// producer (operand pairs) and consumer (final sum).
interface mac_acc_8_bit_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, ovf, busy
  );
endinterface

// File: rtl/mac_acc_8_bit.sv
// Saturating multiply-accumulate over a programmed run of 8-bit operand pairs,
// fed by a combinational 8x8 multiplier and a one-deep product register.
module multi_8_bit (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module mac_acc_8_bit #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  mac_acc_8_bit_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting operand pairs
  // DRAIN | adding the last pending product
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      prod_q, prod_d;
  logic             prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      p;
  logic [ACC_W:0]   sum;
  logic             accept;

  multi_8_bit u_mult (
    .a_i (bus.a),
    .b_i (bus.b),
    .p_o (p)
  );

  assign accept = (state_q == RUN) && bus.in_valid;
  assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
      RUN:   if (accept && rem_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == RUN);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.acc_out   = acc_q;
    bus.ovf       = ovf_q;
  end

  // Accumulate of the previous product and accept of the next pair share an edge.
  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = accept;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    rem_d      = rem_q;
    if (accept) begin
      prod_d = p;
      rem_d  = rem_q - LEN_W'(1);
    end
    if (prod_vld_q) begin
      if (sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
    if (state_q == IDLE && bus.start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      rem_d = bus.len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      rem_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      rem_q      <= rem_d;
    end
  end
endmodule
